axis_spi_reg_bridge: RTL and testbench
======================================

# axis_spi_reg_bridge

Register-access bridge directly downstream and upstream of the AXI-stream SPI slave. It consumes the slave's received-byte stream, decodes each chip-select frame as a command byte followed by data bytes, and drives a simple synchronous register-file port. It feeds read data back into the slave's transmit stream, so an SPI master can burst-read and burst-write registers with auto-increment addressing.

## Interface
- DATA_WIDTH, 8, byte width of both streams and of register data; address width is DATA_WIDTH-1 (7 at default).
- clk  input  1  clock, all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- input_axis_tdata  input  DATA_WIDTH  received SPI byte (from SPI slave output stream)
- input_axis_tvalid  input  1  received byte valid
- input_axis_tready  output  1  bridge accepts received byte
- input_axis_tlast  input  1  byte is last of chip-select frame
- output_axis_tdata  output  DATA_WIDTH  byte to transmit on MISO (to SPI slave input stream)
- output_axis_tvalid  output  1  transmit byte valid
- output_axis_tready  input  1  SPI slave consumed transmit byte
- output_axis_tlast  output  1  tied 0
- reg_addr  output  DATA_WIDTH-1  register address
- reg_wr_en  output  1  one-cycle write strobe
- reg_wr_data  output  DATA_WIDTH  write data
- reg_rd_en  output  1  one-cycle read strobe
- reg_rd_data  input  DATA_WIDTH  read data, valid the cycle after reg_rd_en
- overrun  output  1  one-cycle pulse: prefetched transmit byte overwritten before consumption
- busy  output  1  high when state != CMD or output_axis_tvalid

## Operation
- Frame = command byte then zero or more data bytes; the input_axis_tlast beat ends the frame.
- Command byte: bit DATA_WIDTH-1 = 1 read / 0 write; low DATA_WIDTH-1 bits = start address.
- Address pointer increments after every register access and wraps modulo 2^(DATA_WIDTH-1) (127 -> 0).
- The write path writes data byte n (n>=1) to start+n-1.
- Read path: the SPI slave fetches transmit byte k while it delivers received byte k-1. MISO byte 1 is therefore filler 0. MISO byte n (n>=2) = reg[start+n-2]. Each accepted read-frame beat prefetches the next address.
- States:
  - CMD: tready=1. On a tlast beat, stay in CMD (no access). Otherwise latch the address. Write goes to WRITE. Read asserts reg_rd_en/reg_addr=start next cycle, sets ptr=start+1, and goes to RD_ISSUE.
  - WRITE: tready=1. Each beat asserts reg_wr_en, reg_addr=ptr, reg_wr_data=tdata next cycle, then ptr++. On tlast, go to CMD.
  - RD_ISSUE: tready=0. reg_rd_en high this cycle. Go to RD_CAPTURE.
  - RD_CAPTURE: tready=0. Load reg_rd_data into output_axis_tdata and set output_axis_tvalid. If output_axis_tvalid was already 1 and output_axis_tready was not asserted this cycle, pulse overrun. Go to READ.
  - READ: tready=1. A non-last beat issues a read at ptr, does ptr++, and goes to RD_ISSUE. A tlast beat clears output_axis_tvalid (stale prefetch discarded) and goes to CMD.
- output_axis_tvalid clears on output_axis_tready, or on frame end as above. Data is held until either occurs.
- input_axis_tready is combinational from state. It is 1 in CMD/WRITE/READ, including during reset.

## Timing
- Reset values: all outputs 0 except input_axis_tready=1. State = CMD, ptr=0.
- Write: beat handshake at cycle N -> reg_wr_en high exactly cycle N+1.
- Read: beat at N -> reg_rd_en at N+1 -> reg_rd_data sampled at N+2 -> output_axis_tvalid high from N+3.
- Read-frame throughput: one beat per 3 cycles, well under the 2*DATA_WIDTH-cycle minimum SPI byte time.
- Simultaneous output_axis_tready and RD_CAPTURE load: consumption wins for the old byte, new byte becomes valid, no overrun.
- rst_n low mid-frame: immediate return to reset values. Strobes drop asynchronously. The remainder of the frame is treated as a new frame whose first byte is a command.

## Test plan
- Reset: rst_n low -> all strobes/valids 0, tready 1, busy 0. Release -> first beat treated as a command.
- Burst write: beats 0x05, 0xA1, 0xB2, 0xC3(tlast) -> writes 0xA1@5, 0xB2@6, 0xC3@7, each reg_wr_en one cycle after its beat; then state CMD.
- Burst read: beats 0x90, 0x00, 0x00, 0x00(tlast) with reg[0x10..0x12]=0x11,0x22,0x33 -> output bytes 0x11, then 0x22 (each consumed by tready). On tlast, pending 0x33 is discarded and output_axis_tvalid=0.
- Wrap: write command 0x7F, data 0x01, 0x02 -> writes to addresses 0x7F then 0x00.
- Overrun: read frame with output_axis_tready held 0 over two data beats -> overrun pulses once, output_axis_tdata = newest value.
- Empty frame: single beat 0x83 with tlast -> no reg_rd_en, no reg_wr_en, no output valid. Reset asserted mid-write burst -> next beat decoded as a command.

Source files
------------

// File: rtl/axis_spi_reg_bridge.sv
// Bridges SPI-slave byte streams to a register-file port: command byte, then data bytes,
// with auto-incrementing address. Read data is prefetched into the transmit stream one beat ahead.
module axis_spi_reg_bridge #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,

    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,

    output logic [DATA_WIDTH-2:0] reg_addr,
    output logic                  reg_wr_en,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,

    output logic                  overrun,
    output logic                  busy
);

    localparam int unsigned AW = DATA_WIDTH - 1;
    localparam logic [AW-1:0] PTR_INC = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_CMD,
        S_WRITE,
        S_RD_ISSUE,
        S_RD_CAPTURE,
        S_READ
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [AW-1:0]         r_ptr;
    logic [AW-1:0]         w_ptr_next;
    logic [AW-1:0]         r_addr;
    logic [AW-1:0]         w_addr_next;
    logic                  r_wr_en;
    logic                  w_wr_en_next;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] w_wr_data_next;
    logic                  r_rd_en;
    logic                  w_rd_en_next;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [DATA_WIDTH-1:0] w_tdata_next;
    logic                  r_tvalid;
    logic                  w_tvalid_next;
    logic                  r_overrun;
    logic                  w_overrun_next;

    logic                  w_is_read;
    logic [AW-1:0]         w_cmd_addr;

    assign w_is_read  = input_axis_tdata[DATA_WIDTH-1];
    assign w_cmd_addr = input_axis_tdata[AW-1:0];

    // Ready is a pure function of state so it is already high while reset holds state at CMD.
    assign input_axis_tready = (r_state == S_CMD) || (r_state == S_WRITE) || (r_state == S_READ);

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_addr_next    = r_addr;
        w_wr_en_next   = 1'b0;
        w_wr_data_next = r_wr_data;
        w_rd_en_next   = 1'b0;
        w_tdata_next   = r_tdata;
        w_tvalid_next  = r_tvalid && !output_axis_tready;
        w_overrun_next = 1'b0;

        case (r_state)
            S_CMD: begin
                if (input_axis_tvalid && !input_axis_tlast) begin
                    if (w_is_read) begin
                        w_rd_en_next = 1'b1;
                        w_addr_next  = w_cmd_addr;
                        w_ptr_next   = w_cmd_addr + PTR_INC;
                        w_state_next = S_RD_ISSUE;
                    end else begin
                        w_ptr_next   = w_cmd_addr;
                        w_state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (input_axis_tvalid) begin
                    w_wr_en_next   = 1'b1;
                    w_addr_next    = r_ptr;
                    w_wr_data_next = input_axis_tdata;
                    w_ptr_next     = r_ptr + PTR_INC;
                    if (input_axis_tlast) begin
                        w_state_next = S_CMD;
                    end
                end
            end
            S_RD_ISSUE: begin
                w_state_next = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                // A byte consumed this same cycle is not lost, so only an unconsumed one counts.
                w_tdata_next   = reg_rd_data;
                w_tvalid_next  = 1'b1;
                w_overrun_next = r_tvalid && !output_axis_tready;
                w_state_next   = S_READ;
            end
            S_READ: begin
                if (input_axis_tvalid) begin
                    if (input_axis_tlast) begin
                        w_tvalid_next = 1'b0;
                        w_state_next  = S_CMD;
                    end else begin
                        w_rd_en_next = 1'b1;
                        w_addr_next  = r_ptr;
                        w_ptr_next   = r_ptr + PTR_INC;
                        w_state_next = S_RD_ISSUE;
                    end
                end
            end
            default: begin
                w_state_next = S_CMD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CMD;
            r_ptr     <= '0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_rd_en   <= 1'b0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_addr    <= w_addr_next;
            r_wr_en   <= w_wr_en_next;
            r_wr_data <= w_wr_data_next;
            r_rd_en   <= w_rd_en_next;
            r_tdata   <= w_tdata_next;
            r_tvalid  <= w_tvalid_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign output_axis_tdata  = r_tdata;
    assign output_axis_tvalid = r_tvalid;
    assign output_axis_tlast  = 1'b0;
    assign reg_addr           = r_addr;
    assign reg_wr_en          = r_wr_en;
    assign reg_wr_data        = r_wr_data;
    assign reg_rd_en          = r_rd_en;
    assign overrun            = r_overrun;
    assign busy               = (r_state != S_CMD) || r_tvalid;

endmodule

// File: tb/tb_axis_spi_reg_bridge.sv
// Scoreboard bench for axis_spi_reg_bridge: register writes and transmitted read bytes are
// predicted when frames are driven and compared when the bridge produces them.
module tb_axis_spi_reg_bridge;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_tdata;
    logic       in_tvalid;
    logic       in_tready;
    logic       in_tlast;
    logic [7:0] out_tdata;
    logic       out_tvalid;
    logic       out_tready;
    logic       out_tlast;
    logic [6:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data;
    logic       overrun;
    logic       busy;

    axis_spi_reg_bridge #(.DATA_WIDTH(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_axis_tdata   (in_tdata),
        .input_axis_tvalid  (in_tvalid),
        .input_axis_tready  (in_tready),
        .input_axis_tlast   (in_tlast),
        .output_axis_tdata  (out_tdata),
        .output_axis_tvalid (out_tvalid),
        .output_axis_tready (out_tready),
        .output_axis_tlast  (out_tlast),
        .reg_addr           (reg_addr),
        .reg_wr_en          (reg_wr_en),
        .reg_wr_data        (reg_wr_data),
        .reg_rd_en          (reg_rd_en),
        .reg_rd_data        (reg_rd_data),
        .overrun            (overrun),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  a;
        logic [7:0]  d;
        int unsigned c;
    } wr_t;

    wr_t         wr_q[$];
    logic [7:0]  rd_q[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned neg_cnt = 0;
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    int unsigned ovr_cnt = 0;

    function automatic logic [7:0] init_val(input logic [6:0] a);
        case (a)
            7'h10:   return 8'h11;
            7'h11:   return 8'h22;
            7'h12:   return 8'h33;
            default: return {1'b0, a} ^ 8'hA5;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Register file: read data registered one cycle after the strobe.
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= init_val(reg_addr);
    end

    always @(negedge clk) begin
        neg_cnt <= neg_cnt + 1;
        if (reg_rd_en) rd_cnt <= rd_cnt + 1;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (reg_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (wr_q.size() == 0) begin
                check("wr_unexp", 32'(reg_wr_en), 32'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr_data", 32'({reg_addr, reg_wr_data}), 32'({e.a, e.d}));
                check("wr_cycle", neg_cnt, e.c);
            end
        end
        if (out_tvalid && out_tready) begin
            if (rd_q.size() == 0) begin
                check("rd_unexp", 32'(out_tvalid), 32'd0);
            end else begin
                check("rd_data", 32'(out_tdata), 32'(rd_q.pop_front()));
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l, output int unsigned hs);
        int unsigned n = 0;
        @(negedge clk);
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tlast  = l;
        while (!in_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_tready) check("beat_tmo", 32'(in_tready), 32'd1);
        @(posedge clk);
        #1;
        hs        = neg_cnt;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic wait_valid();
        int unsigned n = 0;
        while (!out_tvalid && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!out_tvalid) check("valid_tmo", 32'(out_tvalid), 32'd1);
    endtask

    task automatic consume();
        wait_valid();
        @(posedge clk);
        #1 out_tready = 1'b1;
        @(posedge clk);
        #1 out_tready = 1'b0;
    endtask

    // n data bytes (1..3) taken from dv, most significant byte first.
    task automatic do_write(input logic [6:0] start, input logic [23:0] dv, input int unsigned n);
        int unsigned hs;
        logic [6:0]  a;
        logic [7:0]  d;
        wr_t         e;
        send_beat({1'b0, start}, 1'b0, hs);
        a = start;
        for (int unsigned i = 0; i < n; i++) begin
            d = dv[23 - 8*i -: 8];
            send_beat(d, (i == n - 1), hs);
            e.a = a;
            e.d = d;
            e.c = hs;
            wr_q.push_back(e);
            a = a + 7'd1;
        end
    endtask

    // Read frame with n dummy data beats; the prefetch pending at tlast is discarded.
    task automatic do_read(input logic [6:0] start, input int unsigned n);
        int unsigned hs;
        logic [6:0]  a;
        rd_q.push_back(init_val(start));
        send_beat({1'b1, start}, 1'b0, hs);
        @(negedge clk);
        check("rd_lat_n1", 32'(out_tvalid), 32'd0);
        @(negedge clk);
        check("rd_lat_n2", 32'(out_tvalid), 32'd0);
        @(negedge clk);
        check("rd_lat_n3", 32'(out_tvalid), 32'd1);
        a = start;
        for (int unsigned i = 1; i <= n; i++) begin
            if (i < n) begin
                consume();
                a = a + 7'd1;
                rd_q.push_back(init_val(a));
                send_beat(8'h00, 1'b0, hs);
            end else begin
                wait_valid();
                send_beat(8'h00, 1'b1, hs);
                void'(rd_q.pop_back());
            end
        end
    endtask

    initial begin
        int unsigned hs;
        int unsigned c0;
        int unsigned c1;
        int unsigned c2;
        wr_t         e;

        rst_n      = 1'b0;
        in_tvalid  = 1'b0;
        in_tdata   = 8'h00;
        in_tlast   = 1'b0;
        out_tready = 1'b0;
        #3;
        check("rst_tready", 32'(in_tready), 32'd1);
        check("rst_tvalid", 32'(out_tvalid), 32'd0);
        check("rst_wr_en", 32'(reg_wr_en), 32'd0);
        check("rst_rd_en", 32'(reg_rd_en), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tlast", 32'(out_tlast), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_write(7'h05, 24'hA1B2C3, 3);
        repeat (3) @(negedge clk);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("wr_busy_idle", 32'(busy), 32'd0);

        do_write(7'h7F, 24'h010200, 2);
        repeat (3) @(negedge clk);
        check("wrap_q_drained", 32'(wr_q.size()), 32'd0);

        c0 = ovr_cnt;
        out_tready = 1'b0;
        do_read(7'h10, 3);
        @(negedge clk);
        check("rd_tvalid_end", 32'(out_tvalid), 32'd0);
        check("rd_busy_end", 32'(busy), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("rd_no_overrun", ovr_cnt, c0);

        c0 = ovr_cnt;
        send_beat(8'hA0, 1'b0, hs);
        wait_valid();
        check("ovr_first", 32'(out_tdata), 32'(init_val(7'h20)));
        send_beat(8'h00, 1'b0, hs);
        repeat (5) @(negedge clk);
        check("ovr_pulses", ovr_cnt - c0, 32'd1);
        check("ovr_newest", 32'(out_tdata), 32'(init_val(7'h21)));
        check("ovr_tvalid", 32'(out_tvalid), 32'd1);
        check("ovr_busy", 32'(busy), 32'd1);
        send_beat(8'h00, 1'b1, hs);
        @(negedge clk);
        check("ovr_tvalid_end", 32'(out_tvalid), 32'd0);

        c0 = rd_cnt;
        c1 = wr_cnt;
        c2 = ovr_cnt;
        send_beat(8'h83, 1'b1, hs);
        repeat (5) @(negedge clk);
        check("empty_rd", rd_cnt, c0);
        check("empty_wr", wr_cnt, c1);
        check("empty_tvalid", 32'(out_tvalid), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_ovr", ovr_cnt, c2);

        send_beat(8'h30, 1'b0, hs);
        send_beat(8'h55, 1'b0, hs);
        e.a = 7'h30;
        e.d = 8'h55;
        e.c = hs;
        wr_q.push_back(e);
        send_beat(8'h56, 1'b0, hs);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_wr_en", 32'(reg_wr_en), 32'd0);
        check("midrst_tready", 32'(in_tready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", 32'(reg_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        c1 = wr_cnt;
        do_write(7'h40, 24'h660000, 1);
        repeat (3) @(negedge clk);
        check("midrst_q_drained", 32'(wr_q.size()), 32'd0);
        check("midrst_wr_count", wr_cnt - c1, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
